// File: rtl/cfu_mac_accum.sv
// CFU MAC stage: int8 x4 dot product with input zero-point offset,
// accumulated into a 32-bit register that feeds the requantizer.
module cfu_mac_accum #(
    parameter int ACC_WIDTH    = 32,
    parameter int OFFSET_RESET = 128,
    parameter bit SATURATE     = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [9:0]           cmd_payload_function_id,
    input  logic [31:0]          cmd_payload_inputs_0,
    input  logic [31:0]          cmd_payload_inputs_1,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ACC_WIDTH-1:0] rsp_payload_outputs_0,
    output logic [ACC_WIDTH-1:0] acc_out
);

    typedef enum logic [1:0] {
        IDLE,
        MAC_SUM,
        RESP
    } state_t;

    localparam logic [6:0] OP_SET_OFFSET = 7'd0;
    localparam logic [6:0] OP_CLEAR      = 7'd1;
    localparam logic [6:0] OP_MAC4       = 7'd2;
    localparam logic [6:0] OP_READ       = 7'd3;
    localparam logic [6:0] OP_ADD_BIAS   = 7'd4;

    state_t                 state;
    state_t                 state_nxt;
    logic [8:0]             offset;
    logic [ACC_WIDTH-1:0]   acc;
    logic [6:0]             funct7;
    logic                   accept;
    logic [9:0]             a_off [4];
    logic signed [17:0]     a18   [4];
    logic signed [17:0]     w18   [4];
    logic signed [17:0]     prod_d [4];
    logic signed [17:0]     prod_q [4];
    logic [19:0]            lane_sum;
    logic [ACC_WIDTH-1:0]   mac_acc;
    logic [ACC_WIDTH-1:0]   bias_acc;
    logic                   unused_fid;

    assign funct7     = cmd_payload_function_id[9:3];
    assign unused_fid = ^cmd_payload_function_id[2:0];
    assign accept     = cmd_valid && cmd_ready;
    assign acc_out    = acc;

    // Overflow only when both addends share a sign the sum does not.
    function automatic logic [ACC_WIDTH-1:0] acc_add(
        input logic [ACC_WIDTH-1:0] x,
        input logic [ACC_WIDTH-1:0] y
    );
        logic [ACC_WIDTH-1:0] s;
        logic                 ovf;
        s   = x + y;
        ovf = (x[ACC_WIDTH-1] == y[ACC_WIDTH-1]) &&
              (s[ACC_WIDTH-1] != x[ACC_WIDTH-1]);
        if (SATURATE && ovf) begin
            s = x[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                               : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_off[i]  = {{2{cmd_payload_inputs_0[8*i+7]}},
                         cmd_payload_inputs_0[8*i +: 8]}
                      + {offset[8], offset};
            a18[i]    = {{8{a_off[i][9]}}, a_off[i]};
            w18[i]    = {{10{cmd_payload_inputs_1[8*i+7]}},
                         cmd_payload_inputs_1[8*i +: 8]};
            prod_d[i] = a18[i] * w18[i];
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < 4; i++) begin
            lane_sum = lane_sum + {{2{prod_q[i][17]}}, prod_q[i]};
        end
    end

    assign mac_acc  = acc_add(acc, {{(ACC_WIDTH-20){lane_sum[19]}}, lane_sum});
    assign bias_acc = acc_add(acc, cmd_payload_inputs_0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = (funct7 == OP_MAC4) ? MAC_SUM : RESP;
                end
            end
            MAC_SUM: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc                   <= '0;
            offset                <= 9'(OFFSET_RESET);
            rsp_payload_outputs_0 <= '0;
            for (int i = 0; i < 4; i++) begin
                prod_q[i] <= '0;
            end
        end else if (accept) begin
            case (funct7)
                OP_SET_OFFSET: begin
                    offset                <= cmd_payload_inputs_0[8:0];
                    rsp_payload_outputs_0 <= {{(ACC_WIDTH-9){offset[8]}}, offset};
                end
                OP_CLEAR: begin
                    acc                   <= '0;
                    rsp_payload_outputs_0 <= acc;
                end
                OP_MAC4: prod_q <= prod_d;
                OP_READ: rsp_payload_outputs_0 <= acc;
                OP_ADD_BIAS: begin
                    acc                   <= bias_acc;
                    rsp_payload_outputs_0 <= bias_acc;
                end
                default: rsp_payload_outputs_0 <= '0;
            endcase
        end else if (state == MAC_SUM) begin
            acc                   <= mac_acc;
            rsp_payload_outputs_0 <= mac_acc;
        end
    end

endmodule

// File: tb/tb_cfu_mac_accum.sv
// Directed bench for cfu_mac_accum; runs a wrapping and a
// saturating instance side by side on the same stimulus.
module tb_cfu_mac_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [9:0]  fn;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        rsp_ready;
    logic        cmd_ready, cmd_ready_s;
    logic        rsp_valid, rsp_valid_s;
    logic [31:0] rsp, rsp_s;
    logic [31:0] acc_out, acc_out_s;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    cfu_mac_accum #(.SATURATE(1'b0)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(fn),
        .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_payload_outputs_0(rsp), .acc_out(acc_out)
    );

    cfu_mac_accum #(.SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_s),
        .cmd_payload_function_id(fn),
        .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
        .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready),
        .rsp_payload_outputs_0(rsp_s), .acc_out(acc_out_s)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h exp %08h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic send(input string tag, input logic [6:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic [31:0] exp_sat,
                        input int exp_lat);
        int lat;
        wait_idle(tag);
        cmd_valid = 1'b1;
        fn        = {op, 3'b101};
        in0       = a;
        in1       = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        fn        = 10'($urandom);
        in0       = $urandom;
        in1       = $urandom;
        lat       = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk(tag, rsp, exp);
        chk({tag, "_sat"}, rsp_s, exp_sat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        fn        = '0;
        in0       = '0;
        in1       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 32'(rsp_valid), 32'd0);
        chk("rst_rdy", 32'(cmd_ready), 32'd1);
        chk("rst_acc", acc_out, 32'h0);
        chk("rst_rsp", rsp, 32'h0);
        reset = 1'b1;

        send("set0", 7'd0, 32'h0, 32'h0, 32'h80, 32'h80, 1);
        send("mac_a", 7'd2, 32'h01020304, 32'h01010101, 32'hA, 32'hA, 2);
        chk("mac_a_acc", acc_out, 32'hA);
        send("set128", 7'd0, 32'hABCDE080, 32'h0, 32'h0, 32'h0, 1);
        send("clr_a", 7'd1, 32'h0, 32'h0, 32'hA, 32'hA, 1);
        send("mac_neg", 7'd2, 32'h0, 32'hFFFFFFFF,
             32'hFFFFFE00, 32'hFFFFFE00, 2);
        send("mac_zero", 7'd2, 32'h80808080, 32'h5A3C7F81,
             32'hFFFFFE00, 32'hFFFFFE00, 2);
        send("set_m1", 7'd0, 32'h1FF, 32'h0, 32'h80, 32'h80, 1);
        send("clr_b", 7'd1, 32'h0, 32'h0, 32'hFFFFFE00, 32'hFFFFFE00, 1);
        send("mac_mix", 7'd2, 32'h7F01FF80, 32'h02FF0380,
             32'h4176, 32'h4176, 2);
        send("set_255", 7'd0, 32'h0FF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        send("clr_c", 7'd1, 32'h0, 32'h0, 32'h4176, 32'h4176, 1);
        send("mac_big", 7'd2, 32'h7F7F7F7F, 32'h80808080,
             32'hFFFD0400, 32'hFFFD0400, 2);
        send("set_back", 7'd0, 32'h080, 32'h0, 32'hFF, 32'hFF, 1);
        send("clr_d", 7'd1, 32'h0, 32'h0, 32'hFFFD0400, 32'hFFFD0400, 1);

        send("bias_max", 7'd4, 32'h7FFFFFFF, 32'h0,
             32'h7FFFFFFF, 32'h7FFFFFFF, 1);
        send("bias_ovf", 7'd4, 32'h1, 32'h0, 32'h80000000, 32'h7FFFFFFF, 1);
        chk("ovf_acc", acc_out, 32'h80000000);
        chk("ovf_acc_sat", acc_out_s, 32'h7FFFFFFF);
        send("clr_ovf", 7'd1, 32'h0, 32'h0, 32'h80000000, 32'h7FFFFFFF, 1);
        send("read0", 7'd3, 32'h1234, 32'h0, 32'h0, 32'h0, 1);
        send("bias_min", 7'd4, 32'h80000000, 32'h0,
             32'h80000000, 32'h80000000, 1);
        send("bias_unf", 7'd4, 32'hFFFFFFFF, 32'h0,
             32'h7FFFFFFF, 32'h80000000, 1);
        send("clr_unf", 7'd1, 32'h0, 32'h0, 32'h7FFFFFFF, 32'h80000000, 1);

        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        send("stall_mac", 7'd2, 32'h01010101, 32'h01010101,
             32'h204, 32'h204, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_data", rsp, 32'h204);
            chk("stall_rdy", 32'(cmd_ready), 32'd0);
            chk("stall_vld", 32'(rsp_valid), 32'd1);
            cmd_valid = (i == 0);
            fn        = {7'd4, 3'b000};
            in0       = 32'h100;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_done", 32'(rsp_valid), 32'd0);
        chk("stall_idle", 32'(cmd_ready), 32'd1);
        send("stall_read", 7'd3, 32'h0, 32'h0, 32'h204, 32'h204, 1);

        send("set5", 7'd0, 32'h5, 32'h0, 32'h80, 32'h80, 1);
        wait_idle("rst_mac");
        cmd_valid = 1'b1;
        fn        = {7'd2, 3'b000};
        in0       = 32'h01010101;
        in1       = 32'h01010101;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rstm_vld", 32'(rsp_valid), 32'd0);
        chk("rstm_acc", acc_out, 32'h0);
        chk("rstm_rsp", rsp, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rstm_quiet", 32'(rsp_valid), 32'd0);
        end
        send("rstm_read", 7'd3, 32'h0, 32'h0, 32'h0, 32'h0, 1);
        send("rstm_off", 7'd0, 32'h080, 32'h0, 32'h80, 32'h80, 1);

        send("bias_55", 7'd4, 32'h55, 32'h0, 32'h55, 32'h55, 1);
        send("op_7f", 7'h7F, 32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0, 1);
        send("op_5", 7'd5, 32'hCAFEF00D, 32'h1, 32'h0, 32'h0, 1);
        send("unk_read", 7'd3, 32'h0, 32'h0, 32'h55, 32'h55, 1);
        send("unk_off", 7'd0, 32'h080, 32'h0, 32'h80, 32'h80, 1);

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cfu_mac_accum.md
Name: cfu_mac_accum

Overview:
- Custom-function MAC stage directly upstream of the CFU quantization stage.
- Consumes packed int8 activation/weight words over the CFU cmd/rsp handshake.
- Applies the input zero-point offset and accumulates four-lane dot products into a 32-bit accumulator.
- Exposes that accumulator to the downstream requantizer, which consumes it as its int32 input.

Parameters:
- ACC_WIDTH, 32, accumulator and response width; must be 32 in this design.
- OFFSET_RESET, 128, signed 9-bit input offset value loaded at reset.
- SATURATE, 0: 0 = two's-complement wrap on accumulator overflow; 1 = clamp to signed min/max.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_payload_function_id  in  10  bits [9:3] = funct7 opcode; [2:0] ignored
- cmd_payload_inputs_0  in  32  operand 0
- cmd_payload_inputs_1  in  32  operand 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  CPU accepts response
- rsp_payload_outputs_0  out  32  response data
- acc_out  out  32  current accumulator, registered, to the quantization stage

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, rsp_valid=0, rsp_payload_outputs_0=0, acc=0, acc_out=0, offset=OFFSET_RESET.
  - Any in-flight MAC is discarded with no response.
- Lane packing: lane i = bits [8i+7:8i], signed int8; lane 0 is the LSB.
- Opcodes (funct7):
  - 0 SET_OFFSET: offset <= inputs_0[8:0] (signed). Response = previous offset, sign-extended.
  - 1 CLEAR: acc <= 0. Response = acc value before clearing.
  - 2 MAC4: acc <= acc + sum over i of (a_i + offset) * w_i, with a from inputs_0 and w from inputs_1. Response = new acc.
  - 3 READ: no state change. Response = acc.
  - 4 ADD_BIAS: acc <= acc + inputs_0. Response = new acc.
  - 5..127: no state change. Response = 0.
- Arithmetic widths:
  - a_i + offset is a 10-bit signed value.
  - Each product is 18-bit signed.
  - The 4-lane sum is 20-bit signed, sign-extended to 32 bits before the accumulator add.
  - Overflow per SATURATE: saturated bounds are 0x7FFFFFFF and 0x80000000.
- FSM:
  - IDLE:
    - cmd_ready=1.
    - On cmd_valid && cmd_ready with MAC4: latch the 4 products into stage registers, go to MAC_SUM.
    - On any other opcode: perform the op, register the response, go to RESP.
  - MAC_SUM: cmd_ready=0. Reduce the products, update acc, register the response, go to RESP.
  - RESP:
    - rsp_valid=1, cmd_ready=0.
    - rsp_payload_outputs_0 is held stable until rsp_valid && rsp_ready; on that edge go to IDLE with rsp_valid=0.
- Latency:
  - Non-MAC: command accepted at edge T, rsp_valid=1 after edge T+1.
  - MAC4: rsp_valid=1 after edge T+2.
  - Back-to-back throughput: one command per 2 cycles (non-MAC) or 3 cycles (MAC4) with rsp_ready tied high.
- cmd_ready is a function of state only; it never depends combinationally on cmd_valid.
- acc_out is updated on the same edge as acc; it is valid whenever state==IDLE or RESP.
- cmd_payload_inputs are sampled only on the acceptance edge; later changes are ignored.

Test Plan:
- Reset, then SET_OFFSET inputs_0=0 -> response 0x00000080. Then MAC4 inputs_0=0x01020304, inputs_1=0x01010101 -> response 0x0000000A, rsp_valid 2 cycles after acceptance, acc_out=0x0000000A.
- Offset 128 (reset default), MAC4 inputs_0=0x00000000, inputs_1=0xFFFFFFFF -> response 0xFFFFFE00. Then MAC4 inputs_0=0x80808080, any weights -> acc unchanged at 0xFFFFFE00.
- ADD_BIAS 0x7FFFFFFF, then ADD_BIAS 1 -> SATURATE=0 gives 0x80000000; SATURATE=1 gives 0x7FFFFFFF. Then CLEAR -> returns the prior value, and READ -> 0.
- Hold rsp_ready low 3 cycles during a MAC4 response -> rsp_payload stable, cmd_ready=0, a cmd_valid pulse is ignored (acc unchanged). Response is consumed the cycle rsp_ready rises.
- Assert reset (0) in the MAC_SUM cycle -> no response, rsp_valid=0, acc_out=0, offset back to 128. Next READ -> 0.
- Unknown opcode 0x7F with nonzero inputs -> response 0, acc and offset unchanged, latency 1 cycle.
